alu_hs: RTL
===========

Name: alu_hs

Overview:
- Parametrised, handshaked successor to the team's single-cycle 8-bit ALU; same opcode map, width set by parameter.
- Adds valid/ready flow control on both sides, status flags, and a sequential shift-add multiplier that returns the full double-width product.
- Sits between the register file / operand bus and the writeback path of the processor datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=4).
- MUL_CYC, WIDTH, multiply latency in cycles, fixed at WIDTH; exposed for bench use only and not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_A  in  WIDTH  operand A.
- IN_B  in  WIDTH  operand B.
- ALU_OP_CODE  in  4  operation select.
- IN_VALID  in  1  operands and opcode valid.
- IN_READY  out  1  block accepts operands this cycle.
- OUT_RESULT  out  WIDTH  result (low half for MUL).
- OUT_HI  out  WIDTH  high half of the MUL product; 0 for all other ops.
- OUT_FLAGS  out  4  {N,V,C,Z}.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer takes the result.

Behaviour:
- Reset: asynchronous assert on RESET_N low. OUT_RESULT, OUT_HI, OUT_FLAGS and OUT_VALID all go to 0. FSM goes to IDLE. IN_READY goes to 0 while reset is asserted and to 1 on the first edge after release.
- Reset mid-operation: reset asserted during BUSY discards the multiply with no residual output.
- Accept: an accept occurs on a CLK edge with IN_VALID && IN_READY.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). The signal is combinational, and the block accepts a new operation in the same cycle the previous result drains.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0 A+B; 1 A-B; 2 A*B (unsigned, 2*WIDTH-bit product).
  - 3 A<<1; 4 A>>1 (logical).
  - 5 A+1; 6 B+1; 7 A-1; 8 B-1.
  - 9 A==B; A A>B; B A<B. Compares are unsigned and return 1 or 0.
  - C A|B; D A&B; E A^B; F pass A.
- Flags:
  - Z = (OUT_RESULT==0), and for MUL, Z = (full product==0).
  - N = MSB of OUT_RESULT.
  - C = carry out for add and increment ops; borrow for subtract and decrement ops; shifted-out bit for ops 3 and 4; 0 otherwise.
  - V = signed overflow for ops 0, 1, 5, 6, 7, 8; 0 otherwise.
- Latency: all ops except MUL complete in 1 cycle. Result, flags and OUT_VALID are registered on the accept edge and visible in the following cycle.
- MUL: OUT_VALID rises exactly WIDTH cycles after the accept edge. Operands are latched at accept, so later changes on IN_A and IN_B are ignored.
- FSM states:
  - IDLE: on a non-MUL accept, load the output register and stay in IDLE. On a MUL accept, go to BUSY and start the multiplier.
  - BUSY: iterate the multiplier. When its done pulse arrives, load the output register and return to IDLE. IN_READY=0 throughout.
- Hold: while OUT_VALID && !OUT_READY, OUT_RESULT, OUT_HI and OUT_FLAGS stay stable and no accept occurs. A pending MUL in BUSY completes only into an empty or draining output register; otherwise it waits in BUSY with its done pulse held.
- Drain: OUT_VALID && OUT_READY with no new completion in the same cycle clears OUT_VALID. Data values may remain.
- Opcode 0xF is a defined pass-through, not an error case.

Decomposition:
- Package alu_hs_pkg holds:
  - opcode localparams (OP_ADD … OP_PASS, 4'h0–4'hF);
  - flag bit indices (FLAG_Z=0, C=1, V=2, N=3);
  - the FSM state encoding (IDLE, BUSY).
- Sub-module alu_mul_seq: parametrised WIDTH, radix-2 shift-add unsigned multiplier.
  - Inputs: start, a, b.
  - Outputs: done (one-cycle pulse, held until acknowledged), prod[2*WIDTH-1:0].
  - Takes exactly WIDTH cycles.

Test Plan:
- WIDTH=8, op 0, A=0xFF, B=0x01 -> OUT_RESULT=0x00, Z=1, C=1, V=0, OUT_VALID one cycle after accept.
- op 1, A=0x80, B=0x01 -> 0x7F, V=1, C=0, N=0. Then op 1, A=0x00, B=0x01 -> 0xFF, C=1 (borrow), N=1.
- op 2, A=200, B=200 -> OUT_HI=0x9C, OUT_RESULT=0x40, OUT_VALID exactly 8 cycles after accept, IN_READY=0 for those 8 cycles, and A/B toggled mid-operation have no effect.
- Backpressure: OUT_READY=0, op 0 (3+4), then IN_VALID held with op 0xE -> IN_READY=0, OUT_RESULT stays 0x07. Raise OUT_READY -> 0x07 taken, 0xE accepted that cycle, its result valid next cycle.
- Reset mid-MUL: RESET_N low in cycle 3 of a MUL -> all outputs 0 immediately (asynchronously). After release, no stale result appears, IN_READY=1, and a fresh op 9 with A=B=0x55 returns 0x01.
- Back-to-back throughput with OUT_READY=1: ops 3 (A=0x81), 4 (A=0x81), F (A=0x5A) on consecutive cycles -> results 0x02/C=1, 0x40/C=1, 0x5A, one per cycle.

Source files
------------

// File: rtl/alu_hs_pkg.sv
// Shared definitions for the handshaked ALU: opcode map, flag bit positions
// and the controller state encoding.
package alu_hs_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_INCA = 4'h5;
  localparam logic [3:0] OP_INCB = 4'h6;
  localparam logic [3:0] OP_DECA = 4'h7;
  localparam logic [3:0] OP_DECB = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_OR   = 4'hC;
  localparam logic [3:0] OP_AND  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier. The first partial product is taken
// on the start edge, so the product is ready STEPS-1 edges later.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int STEPS = WIDTH
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               start,
  input  logic               ack,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0]   cnt_p0;
  logic               busy_p0;
  logic               done_p0;
  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0]   mplier_p0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_p0  <= '0;
      busy_p0 <= 1'b0;
      done_p0 <= 1'b0;
    end else if (start) begin
      cnt_p0  <= CNT_W'(1);
      busy_p0 <= (STEPS > 1);
      done_p0 <= (STEPS == 1);
    end else if (busy_p0) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
      if (cnt_p0 == CNT_W'(STEPS - 1)) begin
        busy_p0 <= 1'b0;
        done_p0 <= 1'b1;
      end
    end else if (done_p0 && ack) begin
      done_p0 <= 1'b0;
    end
  end

  // Datapath carries no reset; it is only observed once done is set.
  always_ff @(posedge CLK) begin
    if (start) begin
      acc_p0    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_p0  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_p0 <= b >> 1;
    end else if (busy_p0) begin
      acc_p0    <= acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  assign done = done_p0;
  assign prod = acc_p0;

endmodule

// File: rtl/alu_hs.sv
// Handshaked ALU: single-cycle ops resolve combinationally into the output
// register; MUL is handed to the sequential multiplier while the FSM waits.
module alu_hs
  import alu_hs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [3:0]       ALU_OP_CODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_RESULT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic [3:0]       OUT_FLAGS,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int MUL_CYC = WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Returns {overflow, carry, sum}.
  function automatic logic [WIDTH+1:0] add_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    logic           v;
    s = {1'b0, x} + {1'b0, y};
    v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    return {v, s};
  endfunction

  // Returns {overflow, borrow, difference}.
  function automatic logic [WIDTH+1:0] sub_f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    logic           v;
    d = {1'b0, x} - {1'b0, y};
    v = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    return {v, d};
  endfunction

  state_t             state_p0, state_nx;
  logic               rdy_en_p0;
  logic               out_free, accept, is_mul;
  logic               mul_start, mul_done, load_alu, load_mul;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags, mul_flags;

  logic [WIDTH-1:0]   res_p1, hi_p1;
  logic [3:0]         flags_p1;
  logic               vld_p1;

  assign out_free  = !vld_p1 || OUT_READY;
  assign IN_READY  = rdy_en_p0 && (state_p0 == IDLE) && out_free;
  assign accept    = IN_VALID && IN_READY;
  assign is_mul    = (ALU_OP_CODE == OP_MUL);
  assign mul_start = accept && is_mul;
  assign load_alu  = accept && !is_mul;
  assign load_mul  = (state_p0 == BUSY) && mul_done && out_free;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .STEPS (MUL_CYC)
  ) u_mul (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (mul_start),
    .ack     (load_mul),
    .a       (IN_A),
    .b       (IN_B),
    .done    (mul_done),
    .prod    (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALU_OP_CODE)
      OP_ADD:  {alu_v, alu_c, alu_res} = add_f(IN_A, IN_B);
      OP_SUB:  {alu_v, alu_c, alu_res} = sub_f(IN_A, IN_B);
      OP_SHL:  begin alu_res = {IN_A[WIDTH-2:0], 1'b0}; alu_c = IN_A[WIDTH-1]; end
      OP_SHR:  begin alu_res = {1'b0, IN_A[WIDTH-1:1]}; alu_c = IN_A[0]; end
      OP_INCA: {alu_v, alu_c, alu_res} = add_f(IN_A, ONE);
      OP_INCB: {alu_v, alu_c, alu_res} = add_f(IN_B, ONE);
      OP_DECA: {alu_v, alu_c, alu_res} = sub_f(IN_A, ONE);
      OP_DECB: {alu_v, alu_c, alu_res} = sub_f(IN_B, ONE);
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A == IN_B)};
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A > IN_B)};
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, (IN_A < IN_B)};
      OP_OR:   alu_res = IN_A | IN_B;
      OP_AND:  alu_res = IN_A & IN_B;
      OP_XOR:  alu_res = IN_A ^ IN_B;
      OP_PASS: alu_res = IN_A;
      default: ;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_prod == '0);
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
  end

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (mul_start) state_nx = BUSY;
      BUSY:    if (load_mul)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_p0  <= IDLE;
      rdy_en_p0 <= 1'b0;
    end else begin
      state_p0  <= state_nx;
      rdy_en_p0 <= 1'b1;
    end
  end

  // Output register stage: one-cycle ops and multiplier completions land here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      res_p1   <= '0;
      hi_p1    <= '0;
      flags_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (load_alu) begin
      res_p1   <= alu_res;
      hi_p1    <= '0;
      flags_p1 <= alu_flags;
      vld_p1   <= 1'b1;
    end else if (load_mul) begin
      res_p1   <= mul_prod[WIDTH-1:0];
      hi_p1    <= mul_prod[2*WIDTH-1:WIDTH];
      flags_p1 <= mul_flags;
      vld_p1   <= 1'b1;
    end else if (OUT_READY) begin
      vld_p1   <= 1'b0;
    end
  end

  assign OUT_RESULT = res_p1;
  assign OUT_HI     = hi_p1;
  assign OUT_FLAGS  = flags_p1;
  assign OUT_VALID  = vld_p1;

endmodule
